// File: rtl/pa_dtu_halt_ctrl.sv
// Debug-halt sequencer: picks one halt source by fixed priority and runs the pending-halt / halt-request handshake with RTU.
// Latency: event -> pending_halt 1 cycle; pending_ack/halt_ack -> next output change 1 cycle; all outputs registered.
// Backpressure: the handshake stalls in PEND/REQ until RTU acks; new events are ignored in REQ/DBG and only upgrade the cause in PEND.
//
// Optional build macro: PA_DTU_HALT_TIMEOUT_EN adds an ack-timeout counter in REQ and the dtu_halt_timeout pulse output.
//
// Ports:
//   forever_cpuclk / cpurst_b           clock, synchronous active-low reset
//   ifu/lsu_trig_hit, *_trig_idx        trigger fires with index (enter-debug action)
//   icount_hit, dm_haltreq, cp0_dtu_step halt sources (icount expiry, level haltreq, dcsr.step)
//   rtu_dtu_retire_vld                  qualifies single-step
//   rtu_dtu_pending_ack/halt_ack        RTU handshake responses
//   rtu_yy_xx_dbgon                     core is in debug mode
//   dtu_rtu_pending_halt/halt_req       handshake outputs to RTU
//   dtu_cause, dtu_hit_idx              dcsr.cause and trigger index of the last halt
//   dtu_busy                            sequencer not idle
//   dtu_halt_timeout                    (macro only) one-cycle pulse when REQ gives up
module pa_dtu_halt_ctrl #(
    parameter int TRIG_NUM    = 4,
    parameter int TRIG_IDX_W  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  ifu_trig_hit,
    input  logic [TRIG_IDX_W-1:0] ifu_trig_idx,
    input  logic                  lsu_trig_hit,
    input  logic [TRIG_IDX_W-1:0] lsu_trig_idx,
    input  logic                  icount_hit,
    input  logic                  dm_haltreq,
    input  logic                  cp0_dtu_step,
    input  logic                  rtu_dtu_retire_vld,
    input  logic                  rtu_dtu_pending_ack,
    input  logic                  rtu_dtu_halt_ack,
    input  logic                  rtu_yy_xx_dbgon,
    output logic                  dtu_rtu_pending_halt,
    output logic                  dtu_rtu_halt_req,
    output logic [3:0]            dtu_cause,
    output logic [TRIG_IDX_W-1:0] dtu_hit_idx,
    output logic                  dtu_busy
`ifdef PA_DTU_HALT_TIMEOUT_EN
    ,
    output logic                  dtu_halt_timeout
`endif
);

    // Elaboration-time parameter sanity.
    if (((1 << TRIG_IDX_W) < TRIG_NUM) || (ACK_TIMEOUT < 1)) begin : g_param_chk
        $error("pa_dtu_halt_ctrl: illegal TRIG_IDX_W/TRIG_NUM/ACK_TIMEOUT");
    end

    localparam logic [3:0] CAUSE_TRIG  = 4'd2;
    localparam logic [3:0] CAUSE_HALT  = 4'd3;
    localparam logic [3:0] CAUSE_STEP  = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_REQ  = 2'd2,
        ST_DBG  = 2'd3
    } state_t;

    // Rank of a cause: higher wins. Unknown/zero cause ranks lowest.
    function automatic logic [1:0] cause_rank(input logic [3:0] c);
        case (c)
            CAUSE_TRIG: cause_rank = 2'd3;
            CAUSE_HALT: cause_rank = 2'd2;
            CAUSE_STEP: cause_rank = 2'd1;
            default:    cause_rank = 2'd0;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic                    pending_halt_q, pending_halt_d;
    logic                    halt_req_q, halt_req_d;
    logic [3:0]              cause_q, cause_d;
    logic [TRIG_IDX_W-1:0]   hit_idx_q, hit_idx_d;
    logic                    busy_q, busy_d;
    // Set once dbgon has been seen high while in DBG; exit needs a real fall.
    logic                    dbg_seen_q, dbg_seen_d;

`ifdef PA_DTU_HALT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0]        ack_cnt_q, ack_cnt_d;
    logic                    halt_timeout_q, halt_timeout_d;
`endif

    // Event qualification: nothing counts while the core is already in debug.
    logic                  evt_en;
    logic                  trig_evt;
    logic                  halt_evt;
    logic                  step_evt;
    logic                  evt_vld;
    logic [3:0]            evt_cause;
    logic [TRIG_IDX_W-1:0] evt_idx;

    assign evt_en   = ~rtu_yy_xx_dbgon;
    assign trig_evt = evt_en & (ifu_trig_hit | lsu_trig_hit | icount_hit);
    assign halt_evt = evt_en & dm_haltreq;
    assign step_evt = evt_en & cp0_dtu_step & rtu_dtu_retire_vld;
    assign evt_vld  = trig_evt | halt_evt | step_evt;

    // Fixed-priority source select: trigger > haltreq > step; LSU > IFU > icount.
    always_comb begin
        evt_cause = 4'd0;
        evt_idx   = '0;
        if (trig_evt) begin
            evt_cause = CAUSE_TRIG;
            if (lsu_trig_hit) begin
                evt_idx = lsu_trig_idx;
            end else if (ifu_trig_hit) begin
                evt_idx = ifu_trig_idx;
            end else begin
                evt_idx = '0;
            end
        end else if (halt_evt) begin
            evt_cause = CAUSE_HALT;
        end else if (step_evt) begin
            evt_cause = CAUSE_STEP;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        hit_idx_d  = hit_idx_q;
        dbg_seen_d = dbg_seen_q;
`ifdef PA_DTU_HALT_TIMEOUT_EN
        ack_cnt_d      = ack_cnt_q;
        halt_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (evt_vld) begin
                    state_d = ST_PEND;
                    cause_d = evt_cause;
                    if (trig_evt) begin
                        hit_idx_d = evt_idx;
                    end
                end
            end
            ST_PEND: begin
                // A same-cycle upgrade is still taken even when the ack lands.
                if (evt_vld && (cause_rank(evt_cause) > cause_rank(cause_q))) begin
                    cause_d = evt_cause;
                    if (trig_evt) begin
                        hit_idx_d = evt_idx;
                    end
                end
                if (rtu_dtu_pending_ack) begin
                    state_d = ST_REQ;
`ifdef PA_DTU_HALT_TIMEOUT_EN
                    ack_cnt_d = '0;
`endif
                end
            end
            ST_REQ: begin
                if (rtu_dtu_halt_ack) begin
                    state_d    = ST_DBG;
                    dbg_seen_d = 1'b0;
                end
`ifdef PA_DTU_HALT_TIMEOUT_EN
                else if (ack_cnt_q == CNT_LAST) begin
                    state_d        = ST_IDLE;
                    cause_d        = 4'd0;
                    halt_timeout_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
`endif
            end
            ST_DBG: begin
                // Events arriving in the exit cycle are dropped; a level
                // haltreq is picked up again from IDLE next cycle.
                if (rtu_yy_xx_dbgon) begin
                    dbg_seen_d = 1'b1;
                end else if (dbg_seen_q) begin
                    state_d    = ST_IDLE;
                    dbg_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are pure functions of the next state so they
        // switch on the same edge as the FSM.
        pending_halt_d = (state_d == ST_PEND);
        halt_req_d     = (state_d == ST_REQ);
        busy_d         = (state_d != ST_IDLE);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q        <= ST_IDLE;
            pending_halt_q <= 1'b0;
            halt_req_q     <= 1'b0;
            cause_q        <= 4'd0;
            hit_idx_q      <= '0;
            busy_q         <= 1'b0;
            dbg_seen_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_halt_q <= pending_halt_d;
            halt_req_q     <= halt_req_d;
            cause_q        <= cause_d;
            hit_idx_q      <= hit_idx_d;
            busy_q         <= busy_d;
            dbg_seen_q     <= dbg_seen_d;
        end
    end

`ifdef PA_DTU_HALT_TIMEOUT_EN
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            ack_cnt_q      <= '0;
            halt_timeout_q <= 1'b0;
        end else begin
            ack_cnt_q      <= ack_cnt_d;
            halt_timeout_q <= halt_timeout_d;
        end
    end

    assign dtu_halt_timeout = halt_timeout_q;
`endif

    assign dtu_rtu_pending_halt = pending_halt_q;
    assign dtu_rtu_halt_req     = halt_req_q;
    assign dtu_cause            = cause_q;
    assign dtu_hit_idx          = hit_idx_q;
    assign dtu_busy             = busy_q;

endmodule

// File: doc/pa_dtu_halt_ctrl.md
Name: pa_dtu_halt_ctrl

Overview:
- Debug-halt sequencer between the trigger logic and the retire unit.
- Collects halt sources: IFU/LSU trigger fires, icount expiry, external haltreq and single-step.
- Selects one source by fixed priority, captures cause and trigger index, and runs the pending-halt then halt-request handshake with RTU.
- Tracks debug mode until exit; owns dtu_cause and the pending_halt view presented to RTU.

Parameters:
- TRIG_NUM, 4, number of implemented triggers.
- TRIG_IDX_W, 2, width of trigger index; must satisfy 2^TRIG_IDX_W >= TRIG_NUM.
- ACK_TIMEOUT, 255, cycles REQ may wait for halt ack; used only with the optional feature.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, synchronous active-low
- ifu_trig_hit  in  1  IFU trigger fired (action = enter debug)
- ifu_trig_idx  in  TRIG_IDX_W  index of firing IFU trigger
- lsu_trig_hit  in  1  LSU trigger fired
- lsu_trig_idx  in  TRIG_IDX_W  index of firing LSU trigger
- icount_hit  in  1  icount trigger reached zero
- dm_haltreq  in  1  level haltreq from debug module
- cp0_dtu_step  in  1  dcsr.step
- rtu_dtu_retire_vld  in  1  instruction retired this cycle
- rtu_dtu_pending_ack  in  1  RTU accepted pending halt
- rtu_dtu_halt_ack  in  1  RTU entered halt
- rtu_yy_xx_dbgon  in  1  core in debug mode
- dtu_rtu_pending_halt  out  1  halt pending, registered
- dtu_rtu_halt_req  out  1  halt request, registered
- dtu_cause  out  4  dcsr.cause of last halt
- dtu_hit_idx  out  TRIG_IDX_W  trigger index of last trigger halt
- dtu_busy  out  1  FSM not IDLE

Behaviour:
- Clocking and reset: single clock domain. All state updates on the rising edge of forever_cpuclk. When cpurst_b=0 at an edge, everything resets; reset overrides any other update and aborts an in-flight handshake.
- Reset values: FSM=IDLE; dtu_rtu_pending_halt=0; dtu_rtu_halt_req=0; dtu_cause=4'd0; dtu_hit_idx=0; dtu_busy=0.
- Event qualification: events count only while rtu_yy_xx_dbgon=0.
  - trig_evt = ifu_trig_hit | lsu_trig_hit | icount_hit.
  - step_evt = cp0_dtu_step & rtu_dtu_retire_vld.
- Priority, highest first: trigger (cause 2) > haltreq (cause 3) > step (cause 4).
  - Within trigger: LSU > IFU > icount. icount reports idx 0.
- FSM states: IDLE, PEND, REQ, DBG.
  - IDLE: on any event, latch cause (and idx if trigger) and go to PEND. dtu_rtu_pending_halt=1 from the next cycle.
  - PEND: a newly arriving event with strictly higher priority overwrites cause/idx; equal or lower priority is ignored. On rtu_dtu_pending_ack go to REQ: pending_halt 1->0 and halt_req 0->1 in the same edge. Cause is frozen from then on.
  - REQ: hold halt_req=1 until rtu_dtu_halt_ack, then go to DBG with halt_req=0.
  - DBG: ignore all events. When rtu_yy_xx_dbgon falls (sampled 0 after being 1 in DBG), return to IDLE. If dbgon never rose, stay in DBG. dtu_cause holds its value.
- Simultaneous events:
  - Ack arriving with a new event in PEND: the ack wins; the upgrade is still applied if it arrives the same cycle.
  - An event in the cycle of the DBG->IDLE transition is dropped. A level dm_haltreq is therefore re-seen next cycle.
- Latency: event to pending_halt is 1 cycle; ack to next output change is 1 cycle.
- dtu_busy = (FSM != IDLE), registered with the state.

Optional Feature:
- Macro: PA_DTU_HALT_TIMEOUT_EN.
- With it defined: an 8+-bit counter clears on REQ entry and increments each REQ cycle. When the count reaches ACK_TIMEOUT without ack:
  - go to IDLE;
  - drop halt_req;
  - pulse a 1-cycle output dtu_halt_timeout;
  - set dtu_cause=0.
- Without it: no counter, no dtu_halt_timeout port; REQ waits indefinitely.

Test Plan:
- Reset: after reset (cpurst_b low for 2 edges, then high), all outputs are 0 and dtu_busy=0.
- Basic trigger halt: lsu_trig_hit=1, idx=2 for 1 cycle -> next cycle pending_halt=1, cause=2, hit_idx=2. pending_ack -> halt_req=1, pending_halt=0. halt_ack -> halt_req=0, busy stays 1. dbgon 1->0 -> busy=0.
- Same-cycle priority: dm_haltreq and step_evt in the same IDLE cycle -> cause=3. Then ifu_trig_hit idx=1 in PEND -> cause=2, idx=1. Then haltreq again in PEND -> cause stays 2.
- Events ignored in debug: in DBG with dbgon=1, pulse icount_hit and dm_haltreq -> no output change. With dm_haltreq held across dbgon falling -> IDLE, then PEND 2 cycles after the fall.
- Reset mid-handshake: assert cpurst_b=0 while in REQ with halt_req=1 -> next edge all outputs 0, FSM IDLE, no stale cause.
- Timeout (PA_DTU_HALT_TIMEOUT_EN, ACK_TIMEOUT=4): enter REQ, withhold halt_ack -> after 4 REQ cycles, dtu_halt_timeout pulses once, halt_req=0, busy=0, cause=0.
